// File: rtl/bus_pkg.sv
// Shared constants for the simple single-master-at-a-time bus and its arbiter.
package bus_pkg;

  localparam int BUS_W = 32;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  // funct3 access-size codes carried on the size field
  localparam logic [2:0] SZ_B  = 3'd0;
  localparam logic [2:0] SZ_H  = 3'd1;
  localparam logic [2:0] SZ_W  = 3'd2;
  localparam logic [2:0] SZ_BU = 3'd4;
  localparam logic [2:0] SZ_HU = 3'd5;

  typedef logic [BUS_W-1:0] word_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr+1 (mod N).
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  int k;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    k         = 0;
    for (int i = 0; i < N; i++) begin
      k = (int'(ptr) + 1 + i) % N;
      if (!valid && req[k]) begin
        valid     = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one simple bus among N_MASTERS, one transaction
// in flight, with a watchdog that force-completes transactions the slave never acks.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 256,
  parameter int CNT_W     = $clog2(TIMEOUT + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [N_MASTERS-1:0]       i_m_bus_en,
  input  logic [N_MASTERS-1:0]       i_m_wr_rd,
  input  logic [BUS_W*N_MASTERS-1:0] i_m_wr_data,
  input  logic [BUS_W*N_MASTERS-1:0] i_m_addr,
  input  logic [3*N_MASTERS-1:0]     i_m_size,
  output logic [N_MASTERS-1:0]       o_m_ack,
  output logic [N_MASTERS-1:0]       o_m_err,
  output logic [BUS_W-1:0]           o_m_rd_data,
  output logic [N_MASTERS-1:0]       o_grant,
  input  logic                       i_ack,
  input  logic [BUS_W-1:0]           i_rd_data,
  output logic                       o_bus_en,
  output logic                       o_wr_rd,
  output logic [BUS_W-1:0]           o_wr_data,
  output logic [BUS_W-1:0]           o_addr,
  output logic [2:0]                 o_size
);

  localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  // A disabled watchdog still needs a legal 1-bit counter
  localparam int CW    = (CNT_W > 0) ? CNT_W : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [0:0]           state;
  logic [N_MASTERS-1:0] grant_oh;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     ptr;
  logic [CW-1:0]        cnt;

  logic [N_MASTERS-1:0] pick_oh;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_vld;

  logic busy;
  logic ack_done;
  logic tmo;
  logic fin;

  rr_arbiter #(
    .N     (N_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req       (i_m_bus_en),
    .ptr       (ptr),
    .grant     (pick_oh),
    .grant_idx (pick_idx),
    .valid     (pick_vld)
  );

  // Outputs are forced quiet while reset is held, even mid-transaction
  assign busy     = (state == BUSY) && !i_rst;
  assign ack_done = busy && i_ack;
  assign tmo      = busy && !i_ack && (TIMEOUT > 0) && (cnt == CNT_LAST);
  assign fin      = ack_done || tmo;

  always_comb begin
    o_bus_en    = busy;
    o_wr_rd     = 1'b0;
    o_wr_data   = '0;
    o_addr      = '0;
    o_size      = '0;
    o_grant     = '0;
    o_m_ack     = '0;
    o_m_err     = '0;
    o_m_rd_data = '0;
    if (busy) begin
      o_wr_rd   = i_m_wr_rd[grant_idx];
      o_wr_data = i_m_wr_data[BUS_W*grant_idx +: BUS_W];
      o_addr    = i_m_addr[BUS_W*grant_idx +: BUS_W];
      o_size    = i_m_size[3*grant_idx +: 3];
      o_grant   = grant_oh;
    end
    if (fin) o_m_ack = grant_oh;
    if (tmo) o_m_err = grant_oh;
    if (ack_done) o_m_rd_data = i_rd_data;
  end

  // Grant is held until ack or watchdog, regardless of the master's bus_en
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      grant_oh  <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= BUSY;
            grant_oh  <= pick_oh;
            grant_idx <= pick_idx;
            cnt       <= '0;
          end
        end
        default: begin
          if (fin) begin
            state    <= IDLE;
            grant_oh <= '0;
            ptr      <= grant_idx;
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with two masters and an 8-cycle watchdog.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_bus_en, m_wr_rd;
  logic [63:0] m_wr_data, m_addr;
  logic [5:0]  m_size;
  logic [1:0]  m_ack, m_err, grant;
  logic [31:0] m_rd_data;
  logic        ack;
  logic [31:0] rd_data;
  logic        bus_en, wr_rd;
  logic [31:0] wr_data, addr;
  logic [2:0]  size;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.N_MASTERS(2), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m_bus_en(m_bus_en), .i_m_wr_rd(m_wr_rd), .i_m_wr_data(m_wr_data),
    .i_m_addr(m_addr), .i_m_size(m_size),
    .o_m_ack(m_ack), .o_m_err(m_err), .o_m_rd_data(m_rd_data), .o_grant(grant),
    .i_ack(ack), .i_rd_data(rd_data),
    .o_bus_en(bus_en), .o_wr_rd(wr_rd), .o_wr_data(wr_data), .o_addr(addr), .o_size(size)
  );

  task automatic test_reset();
    rst = 1'b1; m_bus_en = 2'b11; ack = 1'b1; rd_data = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL rst_bus_en got %b exp 0", bus_en); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rst_m_ack got %b exp 00", m_ack); end
    checks++; if (m_rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd_data got %h exp 0", m_rd_data); end
    @(negedge clk);
    rst = 1'b0; m_bus_en = 2'b00; ack = 1'b0; rd_data = 32'h0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b exp 00", grant); end
    checks++; if (addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", addr); end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m_bus_en = 2'b01; m_wr_rd = 2'b00; m_addr[31:0] = 32'h0000_1000; m_size[2:0] = 3'd2;
    #1;
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL sr_pre_bus_en got %b exp 0", bus_en); end
    @(negedge clk); #1;
    checks++; if (bus_en !== 1'b1) begin errors++; $display("FAIL sr_bus_en1 got %b exp 1", bus_en); end
    checks++; if (addr !== 32'h0000_1000) begin errors++; $display("FAIL sr_addr got %h exp 00001000", addr); end
    checks++; if (wr_rd !== 1'b0) begin errors++; $display("FAIL sr_wr_rd got %b exp 0", wr_rd); end
    checks++; if (size !== 3'd2) begin errors++; $display("FAIL sr_size got %0d exp 2", size); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sr_grant got %b exp 01", grant); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL sr_early_ack got %b exp 00", m_ack); end
    @(negedge clk);
    ack = 1'b1; rd_data = 32'hDEAD_BEEF;
    #1;
    checks++; if (bus_en !== 1'b1) begin errors++; $display("FAIL sr_bus_en2 got %b exp 1", bus_en); end
    checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL sr_ack got %b exp 01", m_ack); end
    checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL sr_err got %b exp 00", m_err); end
    checks++; if (m_rd_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sr_rd_data got %h exp deadbeef", m_rd_data); end
    @(negedge clk);
    ack = 1'b0; m_bus_en = 2'b00; rd_data = 32'h0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sr_post_grant got %b exp 00", grant); end
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL sr_post_bus_en got %b exp 0", bus_en); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL sr_post_ack got %b exp 00", m_ack); end
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    @(negedge clk); rst = 1'b1; m_bus_en = 2'b00;
    @(negedge clk);
    rst = 1'b0; m_bus_en = 2'b11; ack = 1'b1; rd_data = 32'h0000_00A5;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ct_idle0_grant got %b exp 00", grant); end
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b10 : 2'b01;
      @(negedge clk); #1;
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL ct_grant%0d got %b exp %b", i, grant, exp_g); end
      checks++; if (m_ack !== exp_g) begin errors++; $display("FAIL ct_ack%0d got %b exp %b", i, m_ack, exp_g); end
      @(negedge clk);
      if (i == 3) begin m_bus_en = 2'b00; ack = 1'b0; end
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL ct_gap_grant%0d got %b exp 00", i, grant); end
      checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL ct_gap_ack%0d got %b exp 00", i, m_ack); end
    end
  endtask

  task automatic test_write_forwarding();
    @(negedge clk);
    m_bus_en = 2'b10; m_wr_rd = 2'b10;
    m_wr_data = {32'h55AA_00FF, 32'h1111_1111};
    m_addr    = {32'h2000_0004, 32'h0000_0100};
    m_size    = {3'd0, 3'd2};
    #1;
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL wr_pre_bus_en got %b exp 0", bus_en); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wr_grant got %b exp 10", grant); end
    checks++; if (wr_rd !== 1'b1) begin errors++; $display("FAIL wr_wr_rd got %b exp 1", wr_rd); end
    checks++; if (wr_data !== 32'h55AA_00FF) begin errors++; $display("FAIL wr_data got %h exp 55aa00ff", wr_data); end
    checks++; if (addr !== 32'h2000_0004) begin errors++; $display("FAIL wr_addr got %h exp 20000004", addr); end
    checks++; if (size !== 3'd0) begin errors++; $display("FAIL wr_size got %0d exp 0", size); end
    @(negedge clk);
    m_bus_en = 2'b00;
    #1;
    checks++; if (bus_en !== 1'b1) begin errors++; $display("FAIL wr_drop_bus_en got %b exp 1", bus_en); end
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL wr_drop_grant got %b exp 10", grant); end
    checks++; if (addr !== 32'h2000_0004) begin errors++; $display("FAIL wr_drop_addr got %h exp 20000004", addr); end
    @(negedge clk);
    ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL wr_ack got %b exp 10", m_ack); end
    @(negedge clk);
    ack = 1'b0; m_wr_rd = 2'b00;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wr_post_grant got %b exp 00", grant); end
  endtask

  task automatic test_timeout(input logic ack_last);
    @(negedge clk);
    m_bus_en = 2'b01; m_wr_rd = 2'b00; m_addr[31:0] = 32'h0000_3000; ack = 1'b0;
    rd_data = 32'h1234_5678;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 8 && ack_last) begin ack = 1'b1; rd_data = 32'hCAFE_F00D; end
      #1;
      if (c < 8) begin
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL to%0d_early_ack_c%0d got %b exp 00", ack_last, c, m_ack); end
      end else if (ack_last) begin
        checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL toa_ack got %b exp 01", m_ack); end
        checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL toa_err got %b exp 00", m_err); end
        checks++; if (m_rd_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL toa_rd_data got %h exp cafef00d", m_rd_data); end
      end else begin
        checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL to_ack got %b exp 01", m_ack); end
        checks++; if (m_err !== 2'b01) begin errors++; $display("FAIL to_err got %b exp 01", m_err); end
        checks++; if (m_rd_data !== 32'h0) begin errors++; $display("FAIL to_rd_data got %h exp 0", m_rd_data); end
      end
    end
    @(negedge clk);
    m_bus_en = 2'b00; ack = 1'b0; rd_data = 32'h0;
    #1;
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL to%0d_post_bus_en got %b exp 0", ack_last, bus_en); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to%0d_post_grant got %b exp 00", ack_last, grant); end
  endtask

  task automatic test_reset_mid_busy();
    // master1 completes first so the pointer is non-zero before the reset
    @(negedge clk); m_bus_en = 2'b10;
    @(negedge clk); ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL rm_pre_ack got %b exp 10", m_ack); end
    @(negedge clk); ack = 1'b0; m_bus_en = 2'b01;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL rm_busy_grant got %b exp 01", grant); end
    @(negedge clk); rst = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rm_rst_ack got %b exp 00", m_ack); end
    @(negedge clk);
    rst = 1'b0; m_bus_en = 2'b11;
    #1;
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL rm_bus_en got %b exp 0", bus_en); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rm_grant got %b exp 00", grant); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rm_ack got %b exp 00", m_ack); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL rm_first_grant got %b exp 10", grant); end
    @(negedge clk); ack = 1'b1;
    #1;
    checks++; if (m_ack !== 2'b10) begin errors++; $display("FAIL rm_final_ack got %b exp 10", m_ack); end
    @(negedge clk); ack = 1'b0; m_bus_en = 2'b00;
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    ack = 1'b1; rd_data = 32'hAAAA_5555;
    #1;
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL sa_ack got %b exp 00", m_ack); end
    checks++; if (m_rd_data !== 32'h0) begin errors++; $display("FAIL sa_rd_data got %h exp 0", m_rd_data); end
    checks++; if (bus_en !== 1'b0) begin errors++; $display("FAIL sa_bus_en got %b exp 0", bus_en); end
    @(negedge clk);
    ack = 1'b0; rd_data = 32'h0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL sa_grant got %b exp 00", grant); end
    @(negedge clk); m_bus_en = 2'b01;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL sa_next_grant got %b exp 01", grant); end
    checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL sa_next_ack got %b exp 00", m_ack); end
    @(negedge clk); ack = 1'b1;
    @(negedge clk); ack = 1'b0; m_bus_en = 2'b00;
  endtask

  initial begin
    rst = 1'b1; m_bus_en = '0; m_wr_rd = '0; m_wr_data = '0; m_addr = '0; m_size = '0;
    ack = 1'b0; rd_data = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_write_forwarding();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_mid_busy();
    test_stray_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
